// File: rtl/obf_key_pkg.sv
// Shared types and helpers for the serial key loader.
// OBF_KEY_PARITY_EN adds the PARITY state used by the parity-checked build.
package obf_key_pkg;

  localparam int unsigned KEY_WIDTH_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
`ifdef OBF_KEY_PARITY_EN
    ST_PARITY,
`endif
    ST_COMMIT,
    ST_ARMED,
    ST_ERROR
  } obf_key_state_e;

  // Even parity over a zero-extended key image.
  function automatic logic even_parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/obf_key_loader_if.sv
// Serial key-bit stream: one bit per valid/ready handshake, s_0 first.
interface obf_key_loader_if;
  logic key_bit;
  logic key_bit_vld;
  logic key_bit_rdy;

  modport master (output key_bit, output key_bit_vld, input  key_bit_rdy);
  modport slave  (input  key_bit, input  key_bit_vld, output key_bit_rdy);
endinterface

// File: rtl/obf_key_shreg.sv
// Indexed shadow register and bit counter for the key loader.
// done_o flags the shift that writes the final key bit.
module obf_key_shreg
  import obf_key_pkg::*;
#(
  parameter int unsigned KEY_WIDTH = KEY_WIDTH_DEF,
  parameter int unsigned CNT_W     = $clog2(KEY_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 shift_i,
  input  logic                 bit_i,
  output logic [KEY_WIDTH-1:0] shadow_o,
  output logic                 done_o
);

  logic [KEY_WIDTH-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // Counter saturates at KEY_WIDTH so it can never wrap into a valid index.
  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      shadow_d = '0;
      cnt_d    = '0;
    end else if (shift_i && (cnt_q < CNT_W'(KEY_WIDTH))) begin
      for (int i = 0; i < KEY_WIDTH; i++) begin
        if (cnt_q == CNT_W'(i)) shadow_d[i] = bit_i;
      end
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      cnt_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign shadow_o = shadow_q;
  assign done_o   = shift_i && !clr_i && (cnt_q == CNT_W'(KEY_WIDTH - 1));

endmodule

// File: rtl/obf_key_loader.sv
// Serial key loader: collects key bits and swaps them atomically onto key_o.
// Define OBF_KEY_PARITY_EN to require an even-parity bit after the key bits.
//
//   state  | meaning
//   IDLE   | no key committed, SAFE_KEY driven, waiting for start
//   SHIFT  | accepting key bits into the shadow register
//   PARITY | accepting the parity bit (parity build only)
//   COMMIT | one cycle: shadow copied to key_o
//   ARMED  | committed key held; reload only when LOCK_ONCE=0
//   ERROR  | parity failure, SAFE_KEY driven until reset
module obf_key_loader
  import obf_key_pkg::*;
#(
  parameter int unsigned          KEY_WIDTH = KEY_WIDTH_DEF,
  parameter logic [KEY_WIDTH-1:0] SAFE_KEY  = '0,
  parameter bit                   LOCK_ONCE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start_i,
  obf_key_loader_if.slave      key_if,
  output logic [KEY_WIDTH-1:0] key_o,
  output logic                 key_vld_o,
  output logic                 busy_o,
  output logic                 err_o
);

  obf_key_state_e       state_q;
  logic [KEY_WIDTH-1:0] key_q;
  logic [KEY_WIDTH-1:0] shadow;
  logic                 key_vld_q, rdy_q, busy_q;
  logic                 hs, start_ok, shift, done;

  assign hs = key_if.key_bit_vld & rdy_q;

  always_comb begin
    start_ok = 1'b0;
    case (state_q)
      ST_IDLE, ST_SHIFT: start_ok = load_start_i;
`ifdef OBF_KEY_PARITY_EN
      ST_PARITY:         start_ok = load_start_i;
`endif
      ST_ARMED:          start_ok = load_start_i & ~LOCK_ONCE;
      default:           start_ok = 1'b0;
    endcase
  end

  // A start on the same cycle as a bit wins; the bit is dropped.
  assign shift = hs & ~load_start_i & (state_q == ST_SHIFT);

  obf_key_shreg #(.KEY_WIDTH(KEY_WIDTH)) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (start_ok),
    .shift_i  (shift),
    .bit_i    (key_if.key_bit),
    .shadow_o (shadow),
    .done_o   (done)
  );

`ifdef OBF_KEY_PARITY_EN
  logic        err_q;
  logic [63:0] shadow_ext;

  always_comb begin
    shadow_ext                  = '0;
    shadow_ext[KEY_WIDTH-1:0]   = shadow;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      key_q     <= SAFE_KEY;
      key_vld_q <= 1'b0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef OBF_KEY_PARITY_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_ARMED: begin
          if (start_ok) begin
            state_q <= ST_SHIFT;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (done) begin
`ifdef OBF_KEY_PARITY_EN
            state_q <= ST_PARITY;
`else
            state_q <= ST_COMMIT;
            rdy_q   <= 1'b0;
`endif
          end
        end
`ifdef OBF_KEY_PARITY_EN
        ST_PARITY: begin
          if (load_start_i) begin
            state_q <= ST_SHIFT;
          end else if (hs) begin
            rdy_q <= 1'b0;
            if (key_if.key_bit == even_parity(shadow_ext)) begin
              state_q <= ST_COMMIT;
            end else begin
              // Revoke any previously committed key as well.
              state_q   <= ST_ERROR;
              busy_q    <= 1'b0;
              err_q     <= 1'b1;
              key_q     <= SAFE_KEY;
              key_vld_q <= 1'b0;
            end
          end
        end
`endif
        ST_COMMIT: begin
          state_q   <= ST_ARMED;
          key_q     <= shadow;
          key_vld_q <= 1'b1;
          busy_q    <= 1'b0;
        end
        ST_ERROR: begin
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign key_o              = key_q;
  assign key_vld_o          = key_vld_q;
  assign busy_o             = busy_q;
  assign key_if.key_bit_rdy = rdy_q;
`ifdef OBF_KEY_PARITY_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
